// File: rtl/counter_nbit_updown.sv
// Purpose: N-bit modulo-M up/down counter with clear, clamped load, wrap/saturate, tc/carry/ovf.
// Latency: q, carry and ovf update one clk edge after their inputs; tc is combinational from q/t/up.
// Backpressure: none; t is a plain per-cycle enable, and cascading uses tc as the next stage's t.
module counter_nbit_updown #(
   parameter int              WIDTH    = 4,
   parameter longint unsigned MODULUS  = 16,
   parameter int              SATURATE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             t,
   input  logic             up,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             carry,
   output logic             ovf
);

   // Reject illegal width/modulus combinations when the design is elaborated.
   if ((WIDTH < 2) || (WIDTH > 32) || (MODULUS < 64'd2) || (MODULUS > (64'd1 << WIDTH)))
   begin : g_bad_param
      $error("counter_nbit_updown: WIDTH must be 2..32 and MODULUS 2..2^WIDTH");
   end

   // Highest legal count. The explicit compare against it keeps carry/ovf right
   // even when MODULUS = 2^WIDTH and the adder would wrap on its own.
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);

   logic [WIDTH-1:0] cnt_q,   cnt_d;
   logic             carry_q, carry_d;
   logic             ovf_q,   ovf_d;
   logic             at_max;
   logic             at_zero;

   assign at_max  = (cnt_q == MAXV);
   assign at_zero = (cnt_q == '0);

   // Terminal count looks only at the count and the step request, never at carry/ovf,
   // so that a cascaded upper stage can use it directly as its enable.
   assign tc = t & ((up & at_max) | (~up & at_zero));

   // Next-state: clear beats load beats counting; a boundary step either wraps or holds.
   always_comb begin
      cnt_d   = cnt_q;
      carry_d = 1'b0;
      ovf_d   = ovf_q;
      if (clear) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (load) begin
         cnt_d = (load_val > MAXV) ? MAXV : load_val;
      end else if (t) begin
         if (up) begin
            if (at_max) begin
               carry_d = 1'b1;
               ovf_d   = 1'b1;
               cnt_d   = (SATURATE != 0) ? cnt_q : '0;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
            end
         end else begin
            if (at_zero) begin
               carry_d = 1'b1;
               ovf_d   = 1'b1;
               cnt_d   = (SATURATE != 0) ? cnt_q : MAXV;
            end else begin
               cnt_d = cnt_q - WIDTH'(1);
            end
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign q     = cnt_q;
   assign carry = carry_q;
   assign ovf   = ovf_q;

endmodule
